inst_decode: RTL and testbench
==============================

// Module: inst_decode
// PURPOSE
//  Decode stage directly downstream of instruction fetch: accepts one 32-bit RV32I word plus its PC per
//  handshake, splits fields, generates the sign-extended immediate, and classifies the op.
//  Registered output with 2-entry skid buffer gives full throughput under backpressure from execute.
//  Flush input discards all in-flight decoded words on branch redirect.
// PARAMETERS
//  XLEN        32      data/PC width; only 32 is supported.
//  OPC_W       4       width of dec_opclass_o.
// PORTS
//  clk_i           in   1      clock, all state on rising edge
//  rst_n_i         in   1      asynchronous active-low reset
//  dec_inst_i      in   32     instruction word from fetch
//  dec_pc_i        in   32     PC of dec_inst_i
//  dec_valid_i     in   1      fetch word valid
//  dec_ready_o     out  1      decode can accept (handshake = valid_i & ready_o)
//  dec_flush_i     in   1      discard all buffered words
//  dec_valid_o     out  1      decoded bundle valid
//  dec_ready_i     in   1      execute accepts bundle
//  dec_pc_o        out  32     PC of bundle
//  dec_opclass_o   out  4      0 LUI,1 AUIPC,2 JAL,3 JALR,4 BRANCH,5 LOAD,6 STORE,7 OPIMM,8 OP,9 FENCE,10 SYSTEM,15 ILLEGAL
//  dec_rd_o        out  5      dest reg; 0 when unused
//  dec_rs1_o       out  5      src1; 0 when unused (U/J)
//  dec_rs2_o       out  5      src2; 0 when unused (U/I/J)
//  dec_funct3_o    out  3      inst[14:12]
//  dec_funct7b5_o  out  1      inst[30] for OP/OPIMM, else 0
//  dec_imm_o       out  32     immediate, sign-extended
//  dec_we_o        out  1      writes rd (LUI,AUIPC,JAL,JALR,LOAD,OPIMM,OP and rd!=0)
//  dec_illegal_o   out  1      illegal instruction flag
// BEHAVIOUR
//  - Reset (async, rst_n_i=0): every output register and skid entry = 0, dec_valid_o=0; dec_ready_o=1.
//  - Latency 1: word accepted at edge N appears on outputs after edge N (visible in cycle N+1).
//  - dec_ready_o = !skid_valid (register-driven, no combinational path from dec_ready_i).
//  - States: EMPTY (no valid), MAIN (output reg valid), SKID (output + skid valid).
//    EMPTY: accept -> MAIN.  MAIN: out taken & accept -> MAIN (new word); out taken & none -> EMPTY;
//    not taken & accept -> SKID; else stay.  SKID: out taken -> MAIN (skid moves to output); else stay.
//  - Order strictly preserved; no word lost or duplicated; outputs stable while valid_o & !ready_i.
//  - Flush: next edge -> EMPTY, dec_valid_o=0; a word handshaken in the same cycle is dropped
//    (flush wins over accept and over output transfer).
//  - Immediates: I {20{i31},i[31:20]}; S {20{i31},i[31:25],i[11:7]}; B {19{i31},i31,i7,i[30:25],i[11:8],0};
//    U {i[31:12],12'b0}; J {11{i31},i31,i[19:12],i20,i[30:21],0}; R/FENCE/SYSTEM 0.
//  - S/B: rd=0, we=0. Unknown opcode or inst[1:0]!=2'b11 -> opclass 15, all regs 0, imm 0, we=0.
// CONFIGURATION
//  DECODE_ILLEGAL_EN defined: dec_illegal_o=1 for opclass 15 and also for bad funct fields
//    (OP funct7 not 0x00/0x20 or 0x20 with funct3 not 000/101; OPIMM shift funct7 bad; LOAD funct3 011/110/111;
//    STORE funct3 >010; BRANCH funct3 010/011; JALR funct3!=0); such words forced to opclass 15, we=0.
//  Undefined: only the opcode lookup is performed; dec_illegal_o tied 0; funct fields unchecked.
// TESTING
//  1. Assert rst_n_i=0 mid-stream in SKID -> immediately valid_o=0, ready_o=1, all fields 0.
//  2. 0xFFF00093 @pc 0x10 -> next cycle valid_o=1, pc 0x10, opclass 7, rd 1, rs1 0, imm 0xFFFFFFFF, we 1.
//  3. 0xFE208EE3 (beq x1,x2,-4) -> opclass 4, rs1 1, rs2 2, rd 0, imm 0xFFFFFFFC, we 0.
//  4. ready_i=0, 3 back-to-back words -> ready_o=0 after 2nd accepted, 3rd stalled; release -> A,B,C in order, once each.
//  5. In SKID, flush_i=1 with valid_i=1 -> next cycle valid_o=0, ready_o=1, flushed-cycle word never output.
//  6. 0x02000033 -> with DECODE_ILLEGAL_EN opclass 15, illegal 1, we 0; without: opclass 8, illegal 0, we 0 (rd=0).

Source files
------------

// File: rtl/inst_decode.sv
// ---------------------------------------------------------------------------
// inst_decode
//   RV32I decode stage sitting directly behind instruction fetch. Each
//   accepted word is split into its register fields, its immediate is built
//   and sign-extended, and the op is classified. The decoded bundle sits in
//   an output register. A single skid entry behind it lets the stage keep
//   accepting at full rate even though dec_ready_o never depends
//   combinationally on dec_ready_i. A flush drops every buffered word.
//
//   Optional feature macro: DECODE_ILLEGAL_EN
//     defined   : bad funct3/funct7 encodings are also flagged illegal
//                 (forced to opclass 15, all register fields 0, we 0).
//     undefined : only the opcode is checked and dec_illegal_o stays 0.
//
// Ports
//   clk_i, rst_n_i   clock (rising edge) / asynchronous active-low reset
//   dec_inst_i       instruction word from fetch
//   dec_pc_i         PC of dec_inst_i
//   dec_valid_i      fetch word valid
//   dec_ready_o      decode can accept (handshake = dec_valid_i & dec_ready_o)
//   dec_flush_i      discard all buffered words
//   dec_valid_o      decoded bundle valid
//   dec_ready_i      execute accepts the bundle
//   dec_pc_o         PC of the bundle
//   dec_opclass_o    0 LUI,1 AUIPC,2 JAL,3 JALR,4 BRANCH,5 LOAD,6 STORE,
//                    7 OPIMM,8 OP,9 FENCE,10 SYSTEM,15 ILLEGAL
//   dec_rd_o         destination register, 0 when unused
//   dec_rs1_o        source 1, 0 when unused
//   dec_rs2_o        source 2, 0 when unused
//   dec_funct3_o     inst[14:12]
//   dec_funct7b5_o   inst[30] for OP/OPIMM, else 0
//   dec_imm_o        sign-extended immediate
//   dec_we_o         bundle writes rd (never for rd == x0)
//   dec_illegal_o    illegal instruction flag
// ---------------------------------------------------------------------------
module inst_decode #(
  parameter int XLEN  = 32,
  parameter int OPC_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [31:0]      dec_inst_i,
  input  logic [XLEN-1:0]  dec_pc_i,
  input  logic             dec_valid_i,
  output logic             dec_ready_o,
  input  logic             dec_flush_i,
  output logic             dec_valid_o,
  input  logic             dec_ready_i,
  output logic [XLEN-1:0]  dec_pc_o,
  output logic [OPC_W-1:0] dec_opclass_o,
  output logic [4:0]       dec_rd_o,
  output logic [4:0]       dec_rs1_o,
  output logic [4:0]       dec_rs2_o,
  output logic [2:0]       dec_funct3_o,
  output logic             dec_funct7b5_o,
  output logic [XLEN-1:0]  dec_imm_o,
  output logic             dec_we_o,
  output logic             dec_illegal_o
);

  // Major opcodes (inst[6:0], including the 2'b11 length bits).
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [OPC_W-1:0] OC_LUI     = OPC_W'(0);
  localparam logic [OPC_W-1:0] OC_AUIPC   = OPC_W'(1);
  localparam logic [OPC_W-1:0] OC_JAL     = OPC_W'(2);
  localparam logic [OPC_W-1:0] OC_JALR    = OPC_W'(3);
  localparam logic [OPC_W-1:0] OC_BRANCH  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OC_LOAD    = OPC_W'(5);
  localparam logic [OPC_W-1:0] OC_STORE   = OPC_W'(6);
  localparam logic [OPC_W-1:0] OC_OPIMM   = OPC_W'(7);
  localparam logic [OPC_W-1:0] OC_OP      = OPC_W'(8);
  localparam logic [OPC_W-1:0] OC_FENCE   = OPC_W'(9);
  localparam logic [OPC_W-1:0] OC_SYSTEM  = OPC_W'(10);
  localparam logic [OPC_W-1:0] OC_ILLEGAL = OPC_W'(15);

  // Decoded bundle as held in the output register and the skid entry.
  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [OPC_W-1:0] opclass;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic [XLEN-1:0]  imm;
    logic             we;
    logic             illegal;
  } dec_t;

  // Encoding chosen so that bit 0 is "output valid" and bit 1 is
  // "skid valid": both handshake outputs come straight off a flop.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_MAIN  = 2'b01,
    ST_SKID  = 2'b11
  } state_e;

`ifdef DECODE_ILLEGAL_EN
  // Flags reserved funct3/funct7 encodings within otherwise known opcodes.
  function automatic logic funct_fields_bad(input logic [31:0] inst);
    logic [2:0] f3;
    logic [6:0] f7;
    logic       bad;
    f3  = inst[14:12];
    f7  = inst[31:25];
    bad = 1'b0;
    case (inst[6:0])
      OPC_OP: begin
        if (f7 == 7'h00) begin
          bad = 1'b0;
        end else if (f7 == 7'h20) begin
          // Only SUB and SRA use the alternate funct7.
          bad = !((f3 == 3'b000) || (f3 == 3'b101));
        end else begin
          bad = 1'b1;
        end
      end
      OPC_OPIMM: begin
        // Shift-immediates carry funct7 in imm[11:5]; other OPIMM ops do not.
        if (f3 == 3'b001) begin
          bad = (f7 != 7'h00);
        end else if (f3 == 3'b101) begin
          bad = (f7 != 7'h00) && (f7 != 7'h20);
        end else begin
          bad = 1'b0;
        end
      end
      OPC_LOAD:   bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      OPC_STORE:  bad = (f3 > 3'b010);
      OPC_BRANCH: bad = (f3 == 3'b010) || (f3 == 3'b011);
      OPC_JALR:   bad = (f3 != 3'b000);
      default:    bad = 1'b0;
    endcase
    return bad;
  endfunction
`endif

  // Full combinational decode of one fetch word into a bundle.
  function automatic dec_t decode_word(input logic [31:0] inst,
                                       input logic [XLEN-1:0] pc);
    dec_t            d;
    logic [4:0]      rd_f;
    logic [4:0]      rs1_f;
    logic [4:0]      rs2_f;
    logic            bad;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    rd_f  = inst[11:7];
    rs1_f = inst[19:15];
    rs2_f = inst[24:20];
    imm_i = {{20{inst[31]}}, inst[31:20]};
    imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    imm_u = {inst[31:12], 12'h000};
    imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    d        = '0;
    d.pc     = pc;
    d.funct3 = inst[14:12];

    case (inst[6:0])
      OPC_LUI: begin
        d.opclass = OC_LUI;
        d.rd      = rd_f;
        d.imm     = imm_u;
        d.we      = (rd_f != 5'd0);
      end
      OPC_AUIPC: begin
        d.opclass = OC_AUIPC;
        d.rd      = rd_f;
        d.imm     = imm_u;
        d.we      = (rd_f != 5'd0);
      end
      OPC_JAL: begin
        d.opclass = OC_JAL;
        d.rd      = rd_f;
        d.imm     = imm_j;
        d.we      = (rd_f != 5'd0);
      end
      OPC_JALR: begin
        d.opclass = OC_JALR;
        d.rd      = rd_f;
        d.rs1     = rs1_f;
        d.imm     = imm_i;
        d.we      = (rd_f != 5'd0);
      end
      OPC_BRANCH: begin
        d.opclass = OC_BRANCH;
        d.rs1     = rs1_f;
        d.rs2     = rs2_f;
        d.imm     = imm_b;
      end
      OPC_LOAD: begin
        d.opclass = OC_LOAD;
        d.rd      = rd_f;
        d.rs1     = rs1_f;
        d.imm     = imm_i;
        d.we      = (rd_f != 5'd0);
      end
      OPC_STORE: begin
        d.opclass = OC_STORE;
        d.rs1     = rs1_f;
        d.rs2     = rs2_f;
        d.imm     = imm_s;
      end
      OPC_OPIMM: begin
        d.opclass  = OC_OPIMM;
        d.rd       = rd_f;
        d.rs1      = rs1_f;
        d.imm      = imm_i;
        d.funct7b5 = inst[30];
        d.we       = (rd_f != 5'd0);
      end
      OPC_OP: begin
        d.opclass  = OC_OP;
        d.rd       = rd_f;
        d.rs1      = rs1_f;
        d.rs2      = rs2_f;
        d.funct7b5 = inst[30];
        d.we       = (rd_f != 5'd0);
      end
      // FENCE and SYSTEM keep their I-type register fields but no immediate.
      OPC_FENCE: begin
        d.opclass = OC_FENCE;
        d.rd      = rd_f;
        d.rs1     = rs1_f;
      end
      OPC_SYSTEM: begin
        d.opclass = OC_SYSTEM;
        d.rd      = rd_f;
        d.rs1     = rs1_f;
      end
      default: begin
        d.opclass = OC_ILLEGAL;
      end
    endcase

`ifdef DECODE_ILLEGAL_EN
    bad = funct_fields_bad(inst);
`else
    bad = 1'b0;
`endif

    // Anything illegal leaves nothing usable behind except PC and funct3.
    if ((d.opclass == OC_ILLEGAL) || bad) begin
      d.opclass  = OC_ILLEGAL;
      d.rd       = 5'd0;
      d.rs1      = 5'd0;
      d.rs2      = 5'd0;
      d.funct7b5 = 1'b0;
      d.imm      = '0;
      d.we       = 1'b0;
`ifdef DECODE_ILLEGAL_EN
      d.illegal  = 1'b1;
`else
      d.illegal  = 1'b0;
`endif
    end else begin
      d.illegal  = 1'b0;
    end
    return d;
  endfunction

  state_e state_q;
  state_e state_d;
  dec_t   main_q;
  dec_t   main_d;
  dec_t   skid_q;
  dec_t   skid_d;
  dec_t   dec_word_s;
  logic   accept_s;
  logic   take_s;

  assign dec_valid_o = state_q[0];
  assign dec_ready_o = ~state_q[1];
  assign accept_s    = dec_valid_i & dec_ready_o;
  assign take_s      = dec_valid_o & dec_ready_i;

  // Decode the incoming fetch word.
  always_comb begin
    dec_word_s = decode_word(dec_inst_i, dec_pc_i);
  end

  // Next-state and payload steering for the output register and skid entry.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (dec_flush_i) begin
      // Flush beats both the incoming handshake and the outgoing transfer.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            main_d  = dec_word_s;
            state_d = ST_MAIN;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_MAIN: begin
          if (accept_s && (take_s || !dec_ready_i)) begin
            if (take_s) begin
              main_d  = dec_word_s;
              state_d = ST_MAIN;
            end else begin
              skid_d  = dec_word_s;
              state_d = ST_SKID;
            end
          end else if (take_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_MAIN;
          end
        end
        ST_SKID: begin
          // dec_ready_o is low here, so no new word can arrive.
          if (take_s) begin
            main_d  = skid_q;
            state_d = ST_MAIN;
          end else begin
            state_d = ST_SKID;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State, output register and skid entry.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign dec_pc_o       = main_q.pc;
  assign dec_opclass_o  = main_q.opclass;
  assign dec_rd_o       = main_q.rd;
  assign dec_rs1_o      = main_q.rs1;
  assign dec_rs2_o      = main_q.rs2;
  assign dec_funct3_o   = main_q.funct3;
  assign dec_funct7b5_o = main_q.funct7b5;
  assign dec_imm_o      = main_q.imm;
  assign dec_we_o       = main_q.we;
  assign dec_illegal_o  = main_q.illegal;

endmodule

// File: tb/tb_inst_decode.sv
module tb_inst_decode;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] dec_inst_i;
  logic [31:0] dec_pc_i;
  logic        dec_valid_i;
  logic        dec_ready_o;
  logic        dec_flush_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [31:0] dec_pc_o;
  logic [3:0]  dec_opclass_o;
  logic [4:0]  dec_rd_o;
  logic [4:0]  dec_rs1_o;
  logic [4:0]  dec_rs2_o;
  logic [2:0]  dec_funct3_o;
  logic        dec_funct7b5_o;
  logic [31:0] dec_imm_o;
  logic        dec_we_o;
  logic        dec_illegal_o;

  always #5 clk_i = ~clk_i;

  inst_decode dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .dec_inst_i     (dec_inst_i),
    .dec_pc_i       (dec_pc_i),
    .dec_valid_i    (dec_valid_i),
    .dec_ready_o    (dec_ready_o),
    .dec_flush_i    (dec_flush_i),
    .dec_valid_o    (dec_valid_o),
    .dec_ready_i    (dec_ready_i),
    .dec_pc_o       (dec_pc_o),
    .dec_opclass_o  (dec_opclass_o),
    .dec_rd_o       (dec_rd_o),
    .dec_rs1_o      (dec_rs1_o),
    .dec_rs2_o      (dec_rs2_o),
    .dec_funct3_o   (dec_funct3_o),
    .dec_funct7b5_o (dec_funct7b5_o),
    .dec_imm_o      (dec_imm_o),
    .dec_we_o       (dec_we_o),
    .dec_illegal_o  (dec_illegal_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  opclass;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        f7b5;
    logic [31:0] imm;
    logic        we;
    logic        illegal;
  } bun_t;

  int   checks = 0;
  int   errors = 0;
  bun_t model_q[$];

  function automatic bun_t observed();
    bun_t o;
    o = {dec_pc_o, dec_opclass_o, dec_rd_o, dec_rs1_o, dec_rs2_o, dec_funct3_o,
         dec_funct7b5_o, dec_imm_o, dec_we_o, dec_illegal_o};
    return o;
  endfunction

  // Reference decode: classify, pick an instruction format, then assemble
  // fields and immediate arithmetically from that format.
  function automatic bun_t ref_decode(input logic [31:0] w, input logic [31:0] p);
    bun_t        b;
    int          cls;
    byte         fmt;
    int          f3;
    int          f7;
    logic        bad;
    logic [31:0] sx;
    sx  = w[31] ? 32'hFFFF_FFFF : 32'h0000_0000;
    cls = 15;
    fmt = "X";
    f3  = int'(w[14:12]);
    f7  = int'(w[31:25]);
    if (w[1:0] == 2'b11) begin
      case (w[6:2])
        5'b01101: begin cls = 0;  fmt = "U"; end
        5'b00101: begin cls = 1;  fmt = "U"; end
        5'b11011: begin cls = 2;  fmt = "J"; end
        5'b11001: begin cls = 3;  fmt = "I"; end
        5'b11000: begin cls = 4;  fmt = "B"; end
        5'b00000: begin cls = 5;  fmt = "I"; end
        5'b01000: begin cls = 6;  fmt = "S"; end
        5'b00100: begin cls = 7;  fmt = "I"; end
        5'b01100: begin cls = 8;  fmt = "R"; end
        5'b00011: begin cls = 9;  fmt = "N"; end
        5'b11100: begin cls = 10; fmt = "N"; end
        default:  begin cls = 15; fmt = "X"; end
      endcase
    end
    bad = 1'b0;
`ifdef DECODE_ILLEGAL_EN
    case (cls)
      8: bad = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
      7: bad = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32);
      5: bad = (f3 == 3 || f3 == 6 || f3 == 7);
      6: bad = (f3 > 2);
      4: bad = (f3 == 2 || f3 == 3);
      3: bad = (f3 != 0);
      default: bad = 1'b0;
    endcase
`endif
    if (bad) cls = 15;
    b         = '0;
    b.pc      = p;
    b.funct3  = w[14:12];
    b.opclass = 4'(cls);
    if (cls == 15) begin
`ifdef DECODE_ILLEGAL_EN
      b.illegal = 1'b1;
`else
      b.illegal = 1'b0;
`endif
    end else begin
      if (fmt == "U" || fmt == "J" || fmt == "I" || fmt == "R" || fmt == "N") b.rd = w[11:7];
      if (fmt == "I" || fmt == "B" || fmt == "S" || fmt == "R" || fmt == "N") b.rs1 = w[19:15];
      if (fmt == "B" || fmt == "S" || fmt == "R") b.rs2 = w[24:20];
      case (fmt)
        "I": b.imm = (sx << 12) | 32'(w[31:20]);
        "S": b.imm = (sx << 12) | (32'(w[31:25]) << 5) | 32'(w[11:7]);
        "B": b.imm = (sx << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
        "U": b.imm = w & 32'hFFFF_F000;
        "J": b.imm = (sx << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
        default: b.imm = 32'h0000_0000;
      endcase
      b.f7b5 = (cls == 7 || cls == 8) ? w[30] : 1'b0;
      b.we   = (cls inside {0, 1, 2, 3, 5, 7, 8}) && (w[11:7] != 5'd0);
    end
    return b;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 12))
      0:  w[6:0] = 7'b0110111;
      1:  w[6:0] = 7'b0010111;
      2:  w[6:0] = 7'b1101111;
      3:  w[6:0] = 7'b1100111;
      4:  w[6:0] = 7'b1100011;
      5:  w[6:0] = 7'b0000011;
      6:  w[6:0] = 7'b0100011;
      7:  w[6:0] = 7'b0010011;
      8:  w[6:0] = 7'b0110011;
      9:  w[6:0] = 7'b0001111;
      10: w[6:0] = 7'b1110011;
      default: w[6:0] = w[6:0];
    endcase
    if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    if ($urandom_range(0, 3) == 0) w[14:12] = 3'b000;
    return w;
  endfunction

  task automatic idle_inputs();
    dec_inst_i  = 32'h0000_0000;
    dec_pc_i    = 32'h0000_0000;
    dec_valid_i = 1'b0;
    dec_flush_i = 1'b0;
    dec_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    bun_t o;
    idle_inputs();
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", dec_valid_o); end
    checks++;
    if (dec_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", dec_ready_o); end
    o = observed();
    checks++;
    if (o !== bun_t'(0)) begin errors++; $display("FAIL reset_fields got %h want 0", o); end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_directed();
    bun_t o;
    dec_ready_i = 1'b1;
    dec_valid_i = 1'b1;
    dec_inst_i  = 32'hFFF0_0093;
    dec_pc_i    = 32'h0000_0010;
    @(posedge clk_i); #1;
    checks++;
    if ({dec_valid_o, dec_pc_o, dec_opclass_o, dec_rd_o, dec_rs1_o, dec_imm_o, dec_we_o} !==
        {1'b1, 32'h10, 4'd7, 5'd1, 5'd0, 32'hFFFF_FFFF, 1'b1})
    begin
      errors++;
      $display("FAIL addi v=%0b pc=%h cls=%0d rd=%0d rs1=%0d imm=%h we=%0b want 1/10/7/1/0/ffffffff/1",
               dec_valid_o, dec_pc_o, dec_opclass_o, dec_rd_o, dec_rs1_o, dec_imm_o, dec_we_o);
    end
    // Next word follows immediately: output transfer and accept in one cycle.
    dec_inst_i = 32'hFE20_8EE3;
    dec_pc_i   = 32'h0000_0014;
    @(posedge clk_i); #1;
    checks++;
    if ({dec_valid_o, dec_pc_o, dec_opclass_o, dec_rs1_o, dec_rs2_o, dec_rd_o, dec_imm_o, dec_we_o} !==
        {1'b1, 32'h14, 4'd4, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC, 1'b0})
    begin
      errors++;
      $display("FAIL beq v=%0b pc=%h cls=%0d rs1=%0d rs2=%0d rd=%0d imm=%h we=%0b want 1/14/4/1/2/0/fffffffc/0",
               dec_valid_o, dec_pc_o, dec_opclass_o, dec_rs1_o, dec_rs2_o, dec_rd_o, dec_imm_o, dec_we_o);
    end
    o = observed();
    checks++;
    if (o !== ref_decode(32'hFE20_8EE3, 32'h14)) begin
      errors++; $display("FAIL beq_model got %h want %h", o, ref_decode(32'hFE20_8EE3, 32'h14));
    end
    dec_inst_i = 32'h0200_0033;
    dec_pc_i   = 32'h0000_0018;
    @(posedge clk_i); #1;
    dec_valid_i = 1'b0;
    checks++;
`ifdef DECODE_ILLEGAL_EN
    if ({dec_valid_o, dec_opclass_o, dec_illegal_o, dec_we_o} !== {1'b1, 4'd15, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mul_word v=%0b cls=%0d ill=%0b we=%0b want 1/15/1/0", dec_valid_o, dec_opclass_o, dec_illegal_o, dec_we_o);
    end
`else
    if ({dec_valid_o, dec_opclass_o, dec_illegal_o, dec_we_o, dec_rd_o} !== {1'b1, 4'd8, 1'b0, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL mul_word v=%0b cls=%0d ill=%0b we=%0b rd=%0d want 1/8/0/0/0",
               dec_valid_o, dec_opclass_o, dec_illegal_o, dec_we_o, dec_rd_o);
    end
`endif
    @(posedge clk_i); #1;
    checks++;
    if (dec_valid_o !== 1'b0) begin errors++; $display("FAIL drain_empty got %0b want 0", dec_valid_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seen[$];
    dec_ready_i = 1'b0;
    dec_valid_i = 1'b1;
    dec_inst_i  = 32'h0010_0093; dec_pc_i = 32'h0000_0100;
    @(posedge clk_i); #1;
    dec_inst_i  = 32'h0020_0113; dec_pc_i = 32'h0000_0104;
    @(posedge clk_i); #1;
    checks++;
    if (dec_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_ready_low got %0b want 0", dec_ready_o); end
    dec_inst_i  = 32'h0030_0193; dec_pc_i = 32'h0000_0108;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      checks++;
      if ({dec_valid_o, dec_pc_o, dec_ready_o} !== {1'b1, 32'h100, 1'b0}) begin
        errors++; $display("FAIL b2b_stall v=%0b pc=%h rdy=%0b want 1/100/0", dec_valid_o, dec_pc_o, dec_ready_o);
      end
    end
    dec_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (dec_valid_o) seen.push_back(dec_pc_o);
      if (dec_valid_i && dec_ready_o) begin
        @(posedge clk_i); #1;
        dec_valid_i = 1'b0;
      end else begin
        @(posedge clk_i); #1;
      end
    end
    checks++;
    if (seen.size() != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", seen.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= seen.size()) begin
        errors++; $display("FAIL b2b_order[%0d] got none want %h", i, 32'h100 + 32'(4 * i));
      end else if (seen[i] !== 32'h100 + 32'(4 * i)) begin
        errors++; $display("FAIL b2b_order[%0d] got %h want %h", i, seen[i], 32'h100 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_flush();
    int leaked;
    dec_ready_i = 1'b0;
    dec_valid_i = 1'b1;
    dec_inst_i  = 32'h0000_0013; dec_pc_i = 32'h0000_0200;
    @(posedge clk_i); #1;
    dec_pc_i = 32'h0000_0204;
    @(posedge clk_i); #1;
    dec_pc_i    = 32'h0000_0208;
    dec_flush_i = 1'b1;
    @(posedge clk_i); #1;
    dec_flush_i = 1'b0;
    checks++;
    if ({dec_valid_o, dec_ready_o} !== 2'b01) begin
      errors++; $display("FAIL flush_skid v=%0b rdy=%0b want 0/1", dec_valid_o, dec_ready_o);
    end
    // One word in the output register, then flush with both handshakes live.
    dec_pc_i = 32'h0000_020C;
    @(posedge clk_i); #1;
    dec_pc_i    = 32'h0000_0210;
    dec_ready_i = 1'b1;
    dec_flush_i = 1'b1;
    @(posedge clk_i); #1;
    dec_flush_i = 1'b0;
    dec_valid_i = 1'b0;
    checks++;
    if ({dec_valid_o, dec_ready_o} !== 2'b01) begin
      errors++; $display("FAIL flush_main v=%0b rdy=%0b want 0/1", dec_valid_o, dec_ready_o);
    end
    leaked = 0;
    for (int i = 0; i < 5; i++) begin
      if (dec_valid_o) leaked++;
      @(posedge clk_i); #1;
    end
    checks++;
    if (leaked != 0) begin errors++; $display("FAIL flush_leak got %0d words want 0", leaked); end
  endtask

  task automatic test_reset_midstream();
    bun_t o;
    dec_ready_i = 1'b0;
    dec_valid_i = 1'b1;
    dec_inst_i  = 32'h1234_5637; dec_pc_i = 32'h0000_0300;
    @(posedge clk_i); #1;
    dec_pc_i = 32'h0000_0304;
    @(posedge clk_i); #1;
    dec_valid_i = 1'b0;
    #2;
    rst_n_i = 1'b0;
    #1;
    o = observed();
    checks++;
    if ({dec_valid_o, dec_ready_o} !== 2'b01 || o !== bun_t'(0)) begin
      errors++; $display("FAIL reset_mid v=%0b rdy=%0b fields=%h want 0/1/0", dec_valid_o, dec_ready_o, o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_random();
    bun_t o;
    bun_t e;
    logic acc;
    logic take;
    logic flush;
    model_q.delete();
    for (int c = 0; c < 3000; c++) begin
      dec_valid_i = ($urandom_range(0, 3) != 0);
      dec_inst_i  = rand_inst();
      dec_pc_i    = $urandom & 32'hFFFF_FFFC;
      dec_ready_i = ($urandom_range(0, 2) != 0);
      dec_flush_i = ($urandom_range(0, 40) == 0);
      checks++;
      if (dec_ready_o !== (model_q.size() < 2)) begin
        errors++; $display("FAIL rnd_ready cyc %0d got %0b want %0b", c, dec_ready_o, model_q.size() < 2);
      end
      checks++;
      if (dec_valid_o !== (model_q.size() > 0)) begin
        errors++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", c, dec_valid_o, model_q.size() > 0);
      end
      if (model_q.size() > 0) begin
        o = observed();
        e = model_q[0];
        checks++;
        if (o !== e) begin errors++; $display("FAIL rnd_bundle cyc %0d got %h want %h", c, o, e); end
      end
      acc   = dec_valid_i && (model_q.size() < 2);
      take  = dec_ready_i && (model_q.size() > 0);
      flush = dec_flush_i;
      e     = ref_decode(dec_inst_i, dec_pc_i);
      @(posedge clk_i);
      if (flush) begin
        model_q.delete();
      end else begin
        if (take) void'(model_q.pop_front());
        if (acc) model_q.push_back(e);
      end
      #1;
    end
    idle_inputs();
  endtask

  initial begin
    rst_n_i = 1'b0;
    idle_inputs();
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
